// File: rtl/column_cursor.sv
// -----------------------------------------------------------------------------
// column_cursor
//
// Column cursor for a Connect Four board of NUM_COLS columns.
// - Tracks the column the active player is hovering over.
// - Moves it on rising edges of the left/right buttons, skipping full columns.
// - Issues a drop request to the board logic and holds it until acknowledged.
// - After an accepted drop, re-homes the cursor if its column just filled up.
//
// Optional feature (compile-time macro):
//   COLUMN_CURSOR_WRAP_EN - when defined, left/right searches wrap around the
//                           board edges, and the post-drop re-home searches
//                           circularly rightward only. When undefined, searches
//                           stop at the board edges.
//
// Parameters:
//   NUM_COLS   - number of board columns (2..64)
//   START_COL  - cursor value after reset (< NUM_COLS)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   right       in   move-right button (level, synchronised/debounced)
//   left        in   move-left button (level, synchronised/debounced)
//   sel_column  in   drop button (level, synchronised/debounced)
//   col_full    in   bit i set when column i has no free cell
//   drop_ack    in   one-cycle pulse: board logic accepted the drop
//   col         out  current cursor column (registered)
//   drop_valid  out  drop request pending for column col (registered)
//   board_full  out  all columns full (combinational)
// -----------------------------------------------------------------------------
module column_cursor #(
  parameter int NUM_COLS  = 7,
  parameter int START_COL = 3,
  localparam int AW = $clog2(NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                right,
  input  logic                left,
  input  logic                sel_column,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                drop_ack,
  output logic [AW-1:0]       col,
  output logic                drop_valid,
  output logic                board_full
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DROP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t state;

  // Previous button levels; reset to 1 so a button held through reset
  // produces no edge until it is released and pressed again.
  logic right_prev, left_prev, sel_prev;
  logic right_edge, left_edge, sel_edge;

  assign right_edge = right & ~right_prev;
  assign left_edge  = left & ~left_prev;
  assign sel_edge   = sel_column & ~sel_prev;

  assign board_full = &col_full;

  // Nearest non-full column on either side of the cursor.
  logic          right_found, left_found;
  logic [AW-1:0] right_col, left_col;
  logic          settle_found;
  logic [AW-1:0] settle_col;
  int            col_i;
  int            r_idx, l_idx;

  assign col_i = int'(col);

`ifdef COLUMN_CURSOR_WRAP_EN
  // Circular search: walk offsets from the farthest back to 1 so the last
  // hit is the nearest. Offset NUM_COLS (the cursor itself) is never visited.
  always_comb begin
    right_found = 1'b0;
    right_col   = col;
    left_found  = 1'b0;
    left_col    = col;
    r_idx       = 0;
    l_idx       = 0;
    for (int d = NUM_COLS - 1; d >= 1; d--) begin
      r_idx = col_i + d;
      if (r_idx >= NUM_COLS) r_idx = r_idx - NUM_COLS;
      if (!col_full[r_idx]) begin
        right_found = 1'b1;
        right_col   = AW'(r_idx);
      end
      l_idx = col_i - d;
      if (l_idx < 0) l_idx = l_idx + NUM_COLS;
      if (!col_full[l_idx]) begin
        left_found = 1'b1;
        left_col   = AW'(l_idx);
      end
    end
  end

  // Re-home after a drop only ever looks rightward (circularly).
  always_comb begin
    settle_found = right_found;
    settle_col   = right_col;
  end
`else
  // Edge-bounded search. Rightward scan runs high-to-low and leftward scan
  // runs low-to-high so the last hit is the column nearest the cursor.
  always_comb begin
    right_found = 1'b0;
    right_col   = col;
    left_found  = 1'b0;
    left_col    = col;
    r_idx       = 0;
    l_idx       = 0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      r_idx = i;
      if (r_idx > col_i && !col_full[r_idx]) begin
        right_found = 1'b1;
        right_col   = AW'(r_idx);
      end
    end
    for (int i = 0; i < NUM_COLS; i++) begin
      l_idx = i;
      if (l_idx < col_i && !col_full[l_idx]) begin
        left_found = 1'b1;
        left_col   = AW'(l_idx);
      end
    end
  end

  // Re-home after a drop prefers the right side, then falls back left.
  always_comb begin
    settle_found = right_found | left_found;
    settle_col   = right_found ? right_col : left_col;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= AW'(START_COL);
      drop_valid <= 1'b0;
      right_prev <= 1'b1;
      left_prev  <= 1'b1;
      sel_prev   <= 1'b1;
    end else begin
      right_prev <= right;
      left_prev  <= left;
      sel_prev   <= sel_column;

      case (state)
        IDLE: begin
          if (sel_edge && !col_full[col] && !board_full) begin
            // Drop wins over any simultaneous move edge.
            state      <= DROP;
            drop_valid <= 1'b1;
          end else if (right_edge && !left_edge) begin
            if (right_found) col <= right_col;
          end else if (left_edge && !right_edge) begin
            if (left_found) col <= left_col;
          end
        end

        DROP: begin
          // Cursor frozen, all button edges dropped on the floor.
          if (drop_ack) begin
            state      <= SETTLE;
            drop_valid <= 1'b0;
          end
        end

        SETTLE: begin
          // The board has had a cycle to update col_full; move off a column
          // that the drop just filled.
          if (col_full[col] && !board_full && settle_found) col <= settle_col;
          state <= IDLE;
        end

        default: begin
          state      <= IDLE;
          drop_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
